// File: rtl/capture_pkg.sv
`default_nettype none
// ============================================================================
// capture_pkg : state encoding and buffer sizing shared by the capture path
// Revision    : 1.0
// ============================================================================
package capture_pkg;

  localparam int unsigned CAPTURE_ADDR_W = 9;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRETRIG  = 3'd1,
    ST_ARMED    = 3'd2,
    ST_POSTTRIG = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/capture_ctrl.sv
`default_nettype none
// ============================================================================
// capture_ctrl : circular capture RAM writer with pre/post-trigger windows.
//                Optional ARMED timeout trigger under CAPTURE_AUTO_TRIG_EN.
// Revision     : 1.0
// ============================================================================
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int unsigned ADDR_W     = CAPTURE_ADDR_W,
  parameter int unsigned AUTO_LIMIT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        smpl,
  input  logic              wrt_smpl,
  input  logic              run,
  input  logic              trig_pulse,
  input  logic [ADDR_W-1:0] trig_pos,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [7:0]        wdata,
  output logic              armed,
  output logic              triggered,
  output logic              capture_done,
  output logic [ADDR_W-1:0] trig_addr,
  output logic              auto_trig
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] post_len_q, post_len_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              triggered_q, triggered_d;
  logic              armed_q, done_q;

  logic              w_capture;
  logic              w_force;
  logic [ADDR_W-1:0] w_cnt_inc;
  logic [ADDR_W-1:0] w_pre_len;

  // post_len is never 0, so the pre-trigger length always fits in ADDR_W bits
  assign w_pre_len = ADDR_W'(DEPTH - 32'(post_len_q));
  assign w_cnt_inc = cnt_q + ADDR_W'(1);
  assign w_capture = (state_q == ST_PRETRIG) || (state_q == ST_ARMED) ||
                     (state_q == ST_POSTTRIG);

`ifdef CAPTURE_AUTO_TRIG_EN
  localparam int unsigned AUTO_W = $clog2(AUTO_LIMIT + 1);
  logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;
  logic              auto_trig_q, auto_trig_d;

  // A real trigger on the same cycle takes precedence over the timeout
  assign w_force   = wrt_smpl && !trig_pulse && (auto_cnt_q == AUTO_W'(AUTO_LIMIT));
  assign auto_trig = auto_trig_q;
`else
  assign w_force   = 1'b0;
  assign auto_trig = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    cnt_d       = cnt_q;
    post_len_d  = post_len_q;
    trig_addr_d = trig_addr_q;
    triggered_d = triggered_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;
`ifdef CAPTURE_AUTO_TRIG_EN
    auto_cnt_d  = auto_cnt_q;
    auto_trig_d = auto_trig_q;
`endif

    if (run) begin
      state_d     = ST_PRETRIG;
      wptr_d      = '0;
      cnt_d       = '0;
      triggered_d = 1'b0;
      post_len_d  = (trig_pos == '0) ? ADDR_W'(1) : trig_pos;
`ifdef CAPTURE_AUTO_TRIG_EN
      auto_cnt_d  = '0;
      auto_trig_d = 1'b0;
`endif
    end else begin
      if (w_capture && wrt_smpl) begin
        we_d    = 1'b1;
        waddr_d = wptr_q;
        wdata_d = smpl;
        wptr_d  = wptr_q + ADDR_W'(1);
      end

      case (state_q)
        ST_PRETRIG: begin
          if (wrt_smpl) begin
            if (w_cnt_inc == w_pre_len) begin
              state_d = ST_ARMED;
              cnt_d   = '0;
            end else begin
              cnt_d = w_cnt_inc;
            end
          end
        end
        ST_ARMED: begin
          if (trig_pulse || w_force) begin
            state_d     = ST_POSTTRIG;
            triggered_d = 1'b1;
            trig_addr_d = wptr_q;
            cnt_d       = '0;
`ifdef CAPTURE_AUTO_TRIG_EN
            auto_trig_d = w_force;
`endif
            // A coincident strobe is the trigger sample and the first post write
            if (wrt_smpl) begin
              if (post_len_q == ADDR_W'(1)) begin
                state_d = ST_DONE;
              end else begin
                cnt_d = ADDR_W'(1);
              end
            end
          end else if (wrt_smpl) begin
`ifdef CAPTURE_AUTO_TRIG_EN
            auto_cnt_d = auto_cnt_q + AUTO_W'(1);
`endif
          end
        end
        ST_POSTTRIG: begin
          if (wrt_smpl) begin
            if (w_cnt_inc == post_len_q) begin
              state_d = ST_DONE;
            end else begin
              cnt_d = w_cnt_inc;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      cnt_q       <= '0;
      post_len_q  <= ADDR_W'(1);
      trig_addr_q <= '0;
      triggered_q <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
`ifdef CAPTURE_AUTO_TRIG_EN
      auto_cnt_q  <= '0;
      auto_trig_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      post_len_q  <= post_len_d;
      trig_addr_q <= trig_addr_d;
      triggered_q <= triggered_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
      armed_q     <= (state_d == ST_ARMED);
      done_q      <= (state_d == ST_DONE);
`ifdef CAPTURE_AUTO_TRIG_EN
      auto_cnt_q  <= auto_cnt_d;
      auto_trig_q <= auto_trig_d;
`endif
    end
  end

  assign we           = we_q;
  assign waddr        = waddr_q;
  assign wdata        = wdata_q;
  assign armed        = armed_q;
  assign triggered    = triggered_q;
  assign capture_done = done_q;
  assign trig_addr    = trig_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_capture_ctrl.sv
`default_nettype none
// tb_capture_ctrl : directed scenarios plus randomized traffic for capture_ctrl,
//                   with expectations from a write-count model of the capture rules.
module tb_capture_ctrl;

  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int ALIM  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    smpl;
  logic          wrt_smpl, run, trig_pulse;
  logic [AW-1:0] trig_pos;
  logic          we, armed, triggered, capture_done, auto_trig;
  logic [AW-1:0] waddr, trig_addr;
  logic [7:0]    wdata;

  int checks = 0;
  int errors = 0;

  // Model: everything is derived from the number of writes since run
  bit   m_started, m_done, m_auto;
  int   m_nwr, m_trig_wr, m_post, m_trig_addr;
  bit   exp_we;
  int   exp_waddr;
  logic [7:0] exp_wdata;

  capture_ctrl #(.ADDR_W(AW), .AUTO_LIMIT(ALIM)) dut (
    .clk(clk), .rst(rst), .smpl(smpl), .wrt_smpl(wrt_smpl), .run(run),
    .trig_pulse(trig_pulse), .trig_pos(trig_pos), .we(we), .waddr(waddr),
    .wdata(wdata), .armed(armed), .triggered(triggered),
    .capture_done(capture_done), .trig_addr(trig_addr), .auto_trig(auto_trig)
  );

  always #5 clk = ~clk;

  function automatic bit exp_armed();
    return m_started && !m_done && (m_trig_wr == 0) && (m_nwr >= DEPTH - m_post);
  endfunction

  task automatic model(input bit ws, input logic [7:0] d, input bit tp, input bit rn,
                       input int tpos, input bit rs);
    int pre;
    exp_we = 1'b0;
    if (rs) begin
      m_started = 0; m_done = 0; m_auto = 0; m_nwr = 0; m_trig_wr = 0; m_post = 1;
      m_trig_addr = 0; exp_waddr = 0; exp_wdata = 8'h00;
    end else if (rn) begin
      m_started = 1; m_done = 0; m_auto = 0; m_nwr = 0; m_trig_wr = 0;
      m_post = (tpos == 0) ? 1 : tpos;
    end else if (m_started && !m_done) begin
      pre = DEPTH - m_post;
      if (m_trig_wr == 0 && m_nwr >= pre) begin
        if (tp) begin
          m_trig_wr = m_nwr + 1; m_trig_addr = m_nwr % DEPTH;
        end
`ifdef CAPTURE_AUTO_TRIG_EN
        else if (ws && (m_nwr - pre) == ALIM) begin
          m_trig_wr = m_nwr + 1; m_trig_addr = m_nwr % DEPTH; m_auto = 1;
        end
`endif
      end
      if (ws) begin
        m_nwr++;
        exp_we = 1'b1; exp_waddr = (m_nwr - 1) % DEPTH; exp_wdata = d;
      end
      if (m_trig_wr > 0 && m_nwr >= m_trig_wr + m_post - 1) m_done = 1;
    end
  endtask

  task automatic step(input bit ws, input logic [7:0] d, input bit tp, input bit rn,
                      input int tpos, input bit rs);
    wrt_smpl = ws; smpl = d; trig_pulse = tp; run = rn; trig_pos = AW'(tpos); rst = rs;
    model(ws, d, tp, rn, tpos, rs);
    @(posedge clk);
    #1;
    wrt_smpl = 1'b0; trig_pulse = 1'b0; run = 1'b0; rst = 1'b0;
  endtask

  task automatic test_reset();
    step(0, 8'h00, 0, 0, 0, 1);
    step(1, 8'h77, 0, 0, 0, 1);
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", we); end
    checks++; if (waddr !== '0) begin errors++; $display("FAIL reset_waddr: got %0d want 0", waddr); end
    checks++; if (wdata !== 8'h00) begin errors++; $display("FAIL reset_wdata: got %h want 00", wdata); end
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL reset_armed: got %b want 0", armed); end
    checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL reset_triggered: got %b want 0", triggered); end
    checks++; if (capture_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", capture_done); end
    checks++; if (trig_addr !== '0) begin errors++; $display("FAIL reset_trig_addr: got %0d want 0", trig_addr); end
    checks++; if (auto_trig !== 1'b0) begin errors++; $display("FAIL reset_auto: got %b want 0", auto_trig); end
    step(1, 8'h11, 0, 0, 0, 0);
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL idle_no_write: got we=%b want 0", we); end
  endtask

  task automatic test_basic();
    step(0, 8'h00, 0, 1, 4, 0);
    for (int i = 1; i <= 20; i++) begin
      step(1, 8'(i), 0, 0, 0, 0);
      if (i == 11) begin
        checks++; if (armed !== 1'b0) begin errors++; $display("FAIL basic_armed_w11: got %b want 0", armed); end
      end
      if (i == 12) begin
        checks++; if (armed !== 1'b1) begin errors++; $display("FAIL basic_armed_w12: got %b want 1", armed); end
      end
    end
    step(1, 8'd21, 1, 0, 0, 0);
    checks++; if (triggered !== 1'b1) begin errors++; $display("FAIL basic_triggered: got %b want 1", triggered); end
    checks++; if (trig_addr !== 4'd4) begin errors++; $display("FAIL basic_trig_addr: got %0d want 4", trig_addr); end
    checks++; if (armed !== 1'b0) begin errors++; $display("FAIL basic_armed_post: got %b want 0", armed); end
    for (int i = 22; i <= 24; i++) begin
      step(1, 8'(i), 0, 0, 0, 0);
      if (i == 23) begin
        checks++; if (capture_done !== 1'b0) begin errors++; $display("FAIL basic_early_done: got %b want 0", capture_done); end
      end
    end
    checks++; if (capture_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %b want 1", capture_done); end
    checks++; if (waddr !== 4'd7 || we !== 1'b1) begin errors++; $display("FAIL basic_last_waddr: got %0d we=%b want 7 we=1", waddr, we); end
    step(1, 8'd25, 0, 0, 0, 0);
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL basic_done_nowrite: got we=%b want 0", we); end
    checks++; if (capture_done !== 1'b1 || trig_addr !== 4'd4) begin errors++; $display("FAIL basic_done_hold: got done=%b trig_addr=%0d want 1/4", capture_done, trig_addr); end
  endtask

  task automatic test_pretrig_ignore();
    step(0, 8'h00, 0, 1, 4, 0);
    for (int i = 1; i <= 12; i++) begin
      step(1, 8'(i), (i == 5), 0, 0, 0);
      if (i == 5) begin
        checks++; if (triggered !== 1'b0) begin errors++; $display("FAIL pretrig_ignored: got %b want 0", triggered); end
      end
    end
    checks++; if (armed !== 1'b1 || triggered !== 1'b0) begin errors++; $display("FAIL pretrig_then_armed: got armed=%b trig=%b want 1/0", armed, triggered); end
    step(0, 8'h00, 1, 0, 0, 0);
    checks++; if (triggered !== 1'b1 || trig_addr !== 4'd12) begin errors++; $display("FAIL pretrig_later_trig: got trig=%b addr=%0d want 1/12", triggered, trig_addr); end
    for (int i = 13; i <= 16; i++) step(1, 8'(i), 0, 0, 0, 0);
    checks++; if (capture_done !== 1'b1 || waddr !== 4'd15) begin errors++; $display("FAIL pretrig_done: got done=%b waddr=%0d want 1/15", capture_done, waddr); end
  endtask

  task automatic test_trig_pos0();
    step(0, 8'h00, 0, 1, 0, 0);
    for (int i = 1; i <= 15; i++) begin
      step(1, 8'(i), 0, 0, 0, 0);
      if (i == 14) begin
        checks++; if (armed !== 1'b0) begin errors++; $display("FAIL pos0_armed_w14: got %b want 0", armed); end
      end
    end
    checks++; if (armed !== 1'b1) begin errors++; $display("FAIL pos0_armed_w15: got %b want 1", armed); end
    step(1, 8'd16, 1, 0, 0, 0);
    checks++; if (capture_done !== 1'b1 || trig_addr !== 4'd15 || waddr !== 4'd15) begin
      errors++; $display("FAIL pos0_done: got done=%b addr=%0d waddr=%0d want 1/15/15", capture_done, trig_addr, waddr);
    end
  endtask

  task automatic test_reset_mid();
    step(0, 8'h00, 0, 1, 4, 0);
    for (int i = 1; i <= 12; i++) step(1, 8'(i), 0, 0, 0, 0);
    step(1, 8'd13, 1, 0, 0, 0);
    step(1, 8'd14, 0, 0, 0, 0);
    step(1, 8'h3C, 0, 0, 0, 1);
    checks++; if ({we, armed, triggered, capture_done, auto_trig} !== 5'b0 || waddr !== '0 || wdata !== 8'h00 || trig_addr !== '0) begin
      errors++; $display("FAIL midrst_outputs: got we=%b armed=%b trig=%b done=%b auto=%b waddr=%0d wdata=%h taddr=%0d want all 0",
                         we, armed, triggered, capture_done, auto_trig, waddr, wdata, trig_addr);
    end
    step(1, 8'h44, 0, 0, 0, 0);
    checks++; if (we !== 1'b0) begin errors++; $display("FAIL midrst_idle: got we=%b want 0", we); end
    step(0, 8'h00, 0, 1, 4, 0);
    step(1, 8'h55, 0, 0, 0, 0);
    checks++; if (we !== 1'b1 || waddr !== '0 || wdata !== 8'h55) begin
      errors++; $display("FAIL midrst_restart: got we=%b waddr=%0d wdata=%h want 1/0/55", we, waddr, wdata);
    end
  endtask

  task automatic test_decimated();
    step(0, 8'h00, 0, 1, 4, 0);
    for (int c = 0; c < 32; c++) begin
      step((c % 4) == 0, 8'hA5, 0, 0, 0, 0);
      checks++; if (we !== ((c % 4) == 0)) begin errors++; $display("FAIL decim_we c=%0d: got %b want %b", c, we, (c % 4) == 0); end
      if ((c % 4) == 0) begin
        checks++; if (wdata !== 8'hA5 || waddr !== AW'(c / 4)) begin errors++; $display("FAIL decim_data c=%0d: got %h@%0d want a5@%0d", c, wdata, waddr, c / 4); end
      end
    end
  endtask

  task automatic test_auto();
`ifdef CAPTURE_AUTO_TRIG_EN
    step(0, 8'h00, 0, 1, 4, 0);
    for (int i = 1; i <= 20; i++) step(1, 8'(i), 0, 0, 0, 0);
    checks++; if (armed !== 1'b1 || triggered !== 1'b0) begin errors++; $display("FAIL auto_wait: got armed=%b trig=%b want 1/0", armed, triggered); end
    step(1, 8'd21, 0, 0, 0, 0);
    checks++; if (triggered !== 1'b1 || auto_trig !== 1'b1 || trig_addr !== 4'd4) begin
      errors++; $display("FAIL auto_force: got trig=%b auto=%b addr=%0d want 1/1/4", triggered, auto_trig, trig_addr);
    end
    for (int i = 22; i <= 24; i++) step(1, 8'(i), 0, 0, 0, 0);
    checks++; if (capture_done !== 1'b1) begin errors++; $display("FAIL auto_done: got %b want 1", capture_done); end
    step(0, 8'h00, 0, 1, 4, 0);
    for (int i = 1; i <= 20; i++) step(1, 8'(i), 0, 0, 0, 0);
    step(1, 8'd21, 1, 0, 0, 0);
    checks++; if (triggered !== 1'b1 || auto_trig !== 1'b0) begin errors++; $display("FAIL auto_real_wins: got trig=%b auto=%b want 1/0", triggered, auto_trig); end
`else
    step(0, 8'h00, 0, 1, 4, 0);
    for (int i = 1; i <= 52; i++) step(1, 8'(i), 0, 0, 0, 0);
    checks++; if (armed !== 1'b1 || triggered !== 1'b0 || auto_trig !== 1'b0) begin
      errors++; $display("FAIL noauto_wait: got armed=%b trig=%b auto=%b want 1/0/0", armed, triggered, auto_trig);
    end
`endif
  endtask

  task automatic test_random();
    bit ws, tp, rn, rs;
    for (int r = 0; r < 8; r++) begin
      step(0, 8'h00, 0, 1, int'($urandom_range(0, DEPTH - 1)), 0);
      for (int c = 0; c < 150; c++) begin
        rs = ($urandom_range(0, 199) == 0);
        rn = !rs && ($urandom_range(0, 149) == 0);
        ws = !rn && ($urandom_range(0, 9) < 7);
        tp = ($urandom_range(0, 19) == 0);
        step(ws, 8'($urandom), tp, rn, int'($urandom_range(0, DEPTH - 1)), rs);
        checks++; if (we !== exp_we) begin errors++; $display("FAIL rnd_we r%0d c%0d: got %b want %b", r, c, we, exp_we); end
        if (exp_we) begin
          checks++; if (waddr !== AW'(exp_waddr) || wdata !== exp_wdata) begin
            errors++; $display("FAIL rnd_write r%0d c%0d: got %h@%0d want %h@%0d", r, c, wdata, waddr, exp_wdata, exp_waddr);
          end
        end
        checks++; if (armed !== exp_armed()) begin errors++; $display("FAIL rnd_armed r%0d c%0d: got %b want %b", r, c, armed, exp_armed()); end
        checks++; if (triggered !== (m_trig_wr > 0)) begin errors++; $display("FAIL rnd_triggered r%0d c%0d: got %b want %b", r, c, triggered, m_trig_wr > 0); end
        checks++; if (capture_done !== m_done) begin errors++; $display("FAIL rnd_done r%0d c%0d: got %b want %b", r, c, capture_done, m_done); end
        checks++; if (trig_addr !== AW'(m_trig_addr)) begin errors++; $display("FAIL rnd_trig_addr r%0d c%0d: got %0d want %0d", r, c, trig_addr, m_trig_addr); end
        checks++; if (auto_trig !== m_auto) begin errors++; $display("FAIL rnd_auto r%0d c%0d: got %b want %b", r, c, auto_trig, m_auto); end
      end
    end
  endtask

  initial begin
    rst = 1'b1; smpl = 8'h00; wrt_smpl = 1'b0; run = 1'b0; trig_pulse = 1'b0; trig_pos = '0;
    test_reset();
    test_basic();
    test_pretrig_ignore();
    test_trig_pos0();
    test_reset_mid();
    test_decimated();
    test_auto();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
